// File: rtl/uc_pkg.sv
// Shared definitions for the microcontroller sequencer: opcode encodings,
// run/halt state type and the ALU operation driven by non-ALU instructions.
// No logic; imported by uc_decode and uc_seq.
package uc_pkg;

  // Class is selected by Opcode[5:4]; ALU class is any 0x pattern.
  localparam logic [1:0] CLS_LI  = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  // Control-class encodings.
  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_JC   = 6'b110011;
  localparam logic [5:0] OP_SKZ  = 6'b110100;
  localparam logic [5:0] OP_SKNZ = 6'b110101;
  localparam logic [5:0] OP_SKC  = 6'b110110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // ALU operation presented for every non-ALU instruction.
  localparam logic [2:0] ALUOP_NONE = 3'b000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/uc_decode.sv
// Purpose: pure combinational instruction decoder for the sequencer.
// Latency: zero cycles, outputs follow Opcode/flags/state in the same cycle.
// Backpressure: none; only cont (in HALTED) alters PC sequencing.
// Ports: opcode, latched flags, halted/cont in; s_inc, s_skip, s_inm, we,
//        alu_op, illegal_hit, alu_hit, halt_hit out.
// Optional feature: UC_SKIP_EN enables SKZ/SKNZ/SKC; otherwise they are
// illegal NOPs and s_skip is constant 0.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       halted,
  input  logic       cont,
  output logic       s_inc,
  output logic       s_skip,
  output logic       s_inm,
  output logic       we,
  output logic [2:0] alu_op,
  output logic       illegal_hit,
  output logic       alu_hit,
  output logic       halt_hit
);

  always_comb begin
    s_inc       = 1'b1;
    s_skip      = 1'b0;
    s_inm       = 1'b0;
    we          = 1'b0;
    alu_op      = ALUOP_NONE;
    illegal_hit = 1'b0;
    alu_hit     = 1'b0;
    halt_hit    = 1'b0;

    if (halted) begin
      // Hold PC on the HALT word; release past it on the resume cycle.
      s_inc = cont;
    end else if (!opcode[5]) begin
      alu_op  = opcode[4:2];
      we      = 1'b1;
      alu_hit = 1'b1;
    end else if (opcode[5:4] == CLS_LI) begin
      we    = 1'b1;
      s_inm = 1'b1;
    end else begin
      case (opcode)
        OP_J:    s_inc = 1'b0;
        OP_JZ:   s_inc = ~flag_z;
        OP_JNZ:  s_inc = flag_z;
        OP_JC:   s_inc = ~flag_c;
`ifdef UC_SKIP_EN
        OP_SKZ:  s_skip = flag_z;
        OP_SKNZ: s_skip = ~flag_z;
        OP_SKC:  s_skip = flag_c;
`endif
        OP_HALT: begin
          // HALT is a zero-offset jump, so PC reloads itself.
          s_inc    = 1'b0;
          halt_hit = 1'b1;
        end
        default: illegal_hit = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Purpose: sequential control unit; flags, RUN/HALTED FSM, illegal sticky, instret.
// Latency: control outputs combinational in the instruction's cycle; state at next edge.
// Backpressure: none; HALTED stalls PC until cont=1.
// Ports: clk, reset (sync active-low), Opcode, zero, carry, cont in;
//        s_inc, s_skip, s_inm, we, ALUOp, halted, illegal, flag_z, flag_c,
//        instret out.
// Optional feature: UC_SKIP_EN (skip instructions, handled in uc_decode).
module uc_seq
  import uc_pkg::*;
#(
  parameter int INSTRET_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic                 zero,
  input  logic                 carry,
  input  logic                 cont,
  output logic                 s_inc,
  output logic                 s_skip,
  output logic                 s_inm,
  output logic                 we,
  output logic [2:0]           ALUOp,
  output logic                 halted,
  output logic                 illegal,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state_q, state_d;
  logic                 flag_z_q, flag_z_d;
  logic                 flag_c_q, flag_c_d;
  logic                 illegal_q, illegal_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic       dec_inc, dec_skip, dec_inm, dec_we;
  logic [2:0] dec_alu;
  logic       illegal_hit, alu_hit, halt_hit;

  uc_decode u_decode (
    .opcode      (Opcode),
    .flag_z      (flag_z_q),
    .flag_c      (flag_c_q),
    .halted      (state_q == HALTED),
    .cont        (cont),
    .s_inc       (dec_inc),
    .s_skip      (dec_skip),
    .s_inm       (dec_inm),
    .we          (dec_we),
    .alu_op      (dec_alu),
    .illegal_hit (illegal_hit),
    .alu_hit     (alu_hit),
    .halt_hit    (halt_hit)
  );

  // Next-state logic. The decoder already suppresses alu/halt/illegal hits
  // in HALTED, so flags and the sticky bit hold there without extra gating.
  always_comb begin
    state_d   = state_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    illegal_d = illegal_q | illegal_hit;
    instret_d = instret_q;

    case (state_q)
      RUN: begin
        instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
        if (alu_hit) begin
          flag_z_d = zero;
          flag_c_d = carry;
        end
        if (halt_hit) state_d = HALTED;
      end
      HALTED: begin
        if (cont) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // While reset is asserted the datapath sees a harmless PC+1, no-write word.
  always_comb begin
    if (!reset) begin
      s_inc  = 1'b1;
      s_skip = 1'b0;
      s_inm  = 1'b0;
      we     = 1'b0;
      ALUOp  = ALUOP_NONE;
    end else begin
      s_inc  = dec_inc;
      s_skip = dec_skip;
      s_inm  = dec_inm;
      we     = dec_we;
      ALUOp  = dec_alu;
    end
  end

  assign halted  = (state_q == HALTED);
  assign illegal = illegal_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_uc_seq.sv
// Purpose: directed scoreboard bench for uc_seq.
// Latency: expectations are for outputs within the cycle the inputs are applied.
// Backpressure: n/a; one expected observation queued per checked cycle.
module tb_uc_seq;

  typedef struct packed {
    logic        we;
    logic        s_inc;
    logic        s_skip;
    logic        s_inm;
    logic [2:0]  alu;
    logic        halted;
    logic        illegal;
    logic        fz;
    logic        fc;
    logic [15:0] instret;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  Opcode = 6'd0;
  logic        zero = 1'b0;
  logic        carry = 1'b0;
  logic        cont = 1'b0;
  logic        s_inc, s_skip, s_inm, we, halted, illegal, flag_z, flag_c;
  logic [2:0]  ALUOp;
  logic [15:0] instret;

  int checks = 0;
  int errors = 0;

  obs_t  exp_q[$];
  string name_q[$];

`ifdef UC_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  uc_seq #(.INSTRET_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .Opcode  (Opcode),
    .zero    (zero),
    .carry   (carry),
    .cont    (cont),
    .s_inc   (s_inc),
    .s_skip  (s_skip),
    .s_inm   (s_inm),
    .we      (we),
    .ALUOp   (ALUOp),
    .halted  (halted),
    .illegal (illegal),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .instret (instret)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs just after the rising edge; optionally queue
  // the observation expected at the following falling edge.
  task automatic step(input string nm, input bit chk, input logic rst,
                      input logic [5:0] op, input logic z, input logic c,
                      input logic ct, input obs_t e);
    @(posedge clk);
    #1;
    reset  = rst;
    Opcode = op;
    zero   = z;
    carry  = c;
    cont   = ct;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  function automatic obs_t mk(input logic we_e, input logic inc_e,
                              input logic skip_e, input logic inm_e,
                              input logic [2:0] alu_e, input logic halt_e,
                              input logic ill_e, input logic fz_e,
                              input logic fc_e, input logic [15:0] ir_e);
    obs_t o;
    o.we = we_e; o.s_inc = inc_e; o.s_skip = skip_e; o.s_inm = inm_e;
    o.alu = alu_e; o.halted = halt_e; o.illegal = ill_e;
    o.fz = fz_e; o.fc = fc_e; o.instret = ir_e;
    return o;
  endfunction

  // Monitor: every cycle with a pending expectation is compared here.
  initial begin
    obs_t  act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act.we = we; act.s_inc = s_inc; act.s_skip = s_skip; act.s_inm = s_inm;
        act.alu = ALUOp; act.halted = halted; act.illegal = illegal;
        act.fz = flag_z; act.fc = flag_c; act.instret = instret;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got we=%b inc=%b skip=%b inm=%b alu=%b halt=%b ill=%b z=%b c=%b ir=%h, want we=%b inc=%b skip=%b inm=%b alu=%b halt=%b ill=%b z=%b c=%b ir=%h",
                   nm, act.we, act.s_inc, act.s_skip, act.s_inm, act.alu, act.halted,
                   act.illegal, act.fz, act.fc, act.instret,
                   e.we, e.s_inc, e.s_skip, e.s_inm, e.alu, e.halted,
                   e.illegal, e.fz, e.fc, e.instret);
        end
      end
    end
  end

  initial begin
    obs_t nc;
    logic ill_sk;
    nc = '0;
    ill_sk = SKIP_ON ? 1'b0 : 1'b1;

    // Reset: two cycles low, second one checked.
    step("rst0", 0, 0, 6'b000000, 0, 0, 0, nc);
    step("rst1", 1, 0, 6'b000000, 0, 0, 0, mk(0,1,0,0,3'b000,0,0,0,0,16'd0));
    // ALU then branches on the latched flags.
    step("alu_add", 1, 1, 6'b000100, 1, 0, 0, mk(1,1,0,0,3'b001,0,0,0,0,16'd0));
    step("jz_taken", 1, 1, 6'b110001, 0, 1, 0, mk(0,0,0,0,3'b000,0,0,1,0,16'd1));
    step("jc_not", 1, 1, 6'b110011, 0, 1, 0, mk(0,1,0,0,3'b000,0,0,1,0,16'd2));
    step("li", 1, 1, 6'b101010, 0, 1, 0, mk(1,1,0,1,3'b000,0,0,1,0,16'd3));
    step("jnz_after_li", 1, 1, 6'b110010, 0, 0, 0, mk(0,1,0,0,3'b000,0,0,1,0,16'd4));
    step("j", 1, 1, 6'b110000, 0, 0, 0, mk(0,0,0,0,3'b000,0,0,1,0,16'd5));
    step("alu_111", 1, 1, 6'b011100, 0, 1, 0, mk(1,1,0,0,3'b111,0,0,1,0,16'd6));
    step("jc_taken", 1, 1, 6'b110011, 0, 0, 0, mk(0,0,0,0,3'b000,0,0,0,1,16'd7));
    step("skc", 1, 1, 6'b110110, 0, 0, 0, mk(0,1,SKIP_ON,0,3'b000,0,0,0,1,16'd8));
    step("jz_not", 1, 1, 6'b110001, 0, 0, 0, mk(0,1,0,0,3'b000,0,ill_sk,0,1,16'd9));
    // HALT then three halted cycles, then resume.
    step("halt_run", 1, 1, 6'b111111, 0, 0, 0, mk(0,0,0,0,3'b000,0,ill_sk,0,1,16'd10));
    for (int i = 0; i < 3; i++)
      step("halted", 1, 1, 6'b111111, 0, 0, 0, mk(0,0,0,0,3'b000,1,ill_sk,0,1,16'd11));
    step("resume", 1, 1, 6'b111111, 0, 0, 1, mk(0,1,0,0,3'b000,1,ill_sk,0,1,16'd11));
    step("after_resume", 1, 1, 6'b000000, 1, 1, 1, mk(1,1,0,0,3'b000,0,ill_sk,0,1,16'd11));
    step("skz", 1, 1, 6'b110100, 0, 0, 0, mk(0,1,SKIP_ON,0,3'b000,0,ill_sk,1,1,16'd12));
    step("sknz", 1, 1, 6'b110101, 0, 0, 0, mk(0,1,0,0,3'b000,0,ill_sk,1,1,16'd13));
    // Undefined control opcode; sticky bit then stays set.
    step("undef", 1, 1, 6'b111000, 0, 0, 0, mk(0,1,0,0,3'b000,0,ill_sk,1,1,16'd14));
    step("sticky", 1, 1, 6'b000000, 0, 0, 0, mk(1,1,0,0,3'b000,0,1,1,1,16'd15));
    step("halt2", 1, 1, 6'b111111, 0, 0, 0, mk(0,0,0,0,3'b000,0,1,0,0,16'd16));
    // Reset while HALTED with cont high: reset wins, outputs forced.
    step("rst_halted", 1, 0, 6'b111111, 0, 0, 1, mk(0,1,0,0,3'b000,1,1,0,0,16'd17));
    step("post_rst", 1, 1, 6'b000000, 0, 0, 0, mk(1,1,0,0,3'b000,0,0,0,0,16'd0));
    // Counter wrap: advance to all-ones, then one more edge.
    for (int i = 0; i < 65534; i++)
      step("run", 0, 1, 6'b000000, 0, 0, 0, nc);
    step("ir_max", 1, 1, 6'b000000, 0, 0, 0, mk(1,1,0,0,3'b000,0,0,0,0,16'hFFFF));
    step("ir_wrap", 1, 1, 6'b000000, 0, 0, 0, mk(1,1,0,0,3'b000,0,0,0,0,16'h0000));

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
